// File: rtl/mpmc9_pkg.sv
// mpmc9_pkg: shared constants, reservation entry type and line-match helper for the controller
package mpmc9_pkg;
    localparam int NAR = 2;
    localparam int LINE_LSB = 4;
    localparam logic [3:0] NO_CH = 4'hF;
    typedef struct packed {
        logic        v;
        logic [3:0]  ch;
        logic [31:0] adr;
    } resv_entry_t;
    typedef enum logic [1:0] {SEL_OWN, SEL_FREE, SEL_VICT} alloc_sel_t;
    function automatic logic line_match(input logic [31:0] a, input logic [31:0] b);
        return a[31:LINE_LSB] == b[31:LINE_LSB];
    endfunction
endpackage

// File: rtl/mpmc9_resv_alloc.sv
// mpmc9_resv_alloc: picks the reservation slot (own entry, else lowest free, else victim)
module mpmc9_resv_alloc
    import mpmc9_pkg::*;
(
    input  logic [NAR-1:0] valid,
    input  logic [NAR-1:0] own,
    input  logic [2:0]     victim,
    output logic [2:0]     idx,
    output logic [1:0]     sel
);
    always_comb begin
        idx = victim;
        sel = SEL_VICT;
        // descending scans leave the lowest index; the owner scan runs last so it wins
        for (int i = NAR - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                idx = 3'(i);
                sel = SEL_FREE;
            end
        end
        for (int i = NAR - 1; i >= 0; i--) begin
            if (own[i]) begin
                idx = 3'(i);
                sel = SEL_OWN;
            end
        end
    end
endmodule

// File: rtl/mpmc9_resv_ctrl.sv
// mpmc9_resv_ctrl: load-reserve/store-conditional reservation table with write snoop and channel clear
module mpmc9_resv_ctrl
    import mpmc9_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               rsv_req,
    input  logic [3:0]         rsv_ch,
    input  logic [31:0]        rsv_adr,
    output logic               rsv_ack,
    input  logic               wr_req,
    input  logic [31:0]        wr_adr,
    input  logic               clr_req,
    input  logic [3:0]         clr_ch,
    output logic [4*NAR-1:0]   resv_ch,
    output logic [32*NAR-1:0]  resv_adr,
    output logic [3:0]         resv_cnt,
    output logic [2:0]         victim
);
    resv_entry_t    tab   [NAR];
    resv_entry_t    mid   [NAR];
    resv_entry_t    tab_n [NAR];
    logic [NAR-1:0] mid_v;
    logic [NAR-1:0] own;
    logic [2:0]     idx;
    logic [2:0]     vic_n;
    logic [1:0]     sel;
    logic           ack_n;
    logic [3:0]     cnt_n;

    always_comb begin
        for (int i = 0; i < NAR; i++) begin
            mid[i] = tab[i];
            if ((wr_req && line_match(tab[i].adr, wr_adr)) || (clr_req && tab[i].ch == clr_ch))
                mid[i].v = 1'b0;
            mid_v[i] = mid[i].v;
            own[i]   = mid[i].v && mid[i].ch == rsv_ch;
        end
    end

    mpmc9_resv_alloc u_alloc (
        .valid  (mid_v),
        .own    (own),
        .victim (victim),
        .idx    (idx),
        .sel    (sel)
    );

    always_comb begin
        tab_n = mid;
        ack_n = rsv_req && rsv_ch != NO_CH;
        vic_n = (ack_n && sel == SEL_VICT) ? (victim == 3'(NAR - 1) ? 3'd0 : victim + 3'd1) : victim;
        cnt_n = '0;
        for (int i = 0; i < NAR; i++) begin
            if (ack_n && idx == 3'(i))
                tab_n[i] = '{v: 1'b1, ch: rsv_ch, adr: rsv_adr};
            cnt_n = cnt_n + 4'(tab_n[i].v);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NAR; i++)
                tab[i] <= '0;
            victim   <= '0;
            rsv_ack  <= 1'b0;
            resv_cnt <= '0;
        end else begin
            tab      <= tab_n;
            victim   <= vic_n;
            rsv_ack  <= ack_n;
            resv_cnt <= cnt_n;
        end
    end

    for (genvar g = 0; g < NAR; g++) begin : g_out
        assign resv_ch[4*g +: 4]   = tab[g].v ? tab[g].ch : NO_CH;
        assign resv_adr[32*g +: 32] = tab[g].v ? tab[g].adr : 32'h0;
    end
endmodule
